// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with synchroniser, midpoint sampling, FWFT receive FIFO and sticky error flags.
// Optional even-parity check between data and stop bits is built when UART_RX_PARITY_EN is defined.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 12,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rx_i,
    input  logic                         rd_en,
    input  logic                         err_clr,
    output logic [7:0]                   rd_data,
    output logic                         rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         frame_err,
    output logic                         overrun
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_BIT  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
    } state_t;
`endif

    logic          sync1_q, sync2_q, armed_q;
    logic          rx_s;
    state_t        state_q;
    logic [TW-1:0] tmr_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          push_req, stop_bad, par_bad;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          frame_err_q, overrun_q;
    logic          pop, full, wr_ok, ovr_set;

    assign rx_s = sync2_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            // a start edge is only accepted once the line has been seen high
            armed_q <= armed_q | sync2_q;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_ok_q;
    assign push_req = (state_q == S_STOP) && (tmr_q == '0) && rx_s && par_ok_q;
    assign par_bad  = (state_q == S_PARITY) && (tmr_q == '0) && (rx_s != ^shift_q);
`else
    assign push_req = (state_q == S_STOP) && (tmr_q == '0) && rx_s;
    assign par_bad  = 1'b0;
`endif
    assign stop_bad = (state_q == S_STOP) && (tmr_q == '0) && !rx_s;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_ok_q  <= 1'b1;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (armed_q && !rx_s) begin
                        state_q   <= S_START;
                        tmr_q     <= T_HALF;
                        bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                        par_ok_q  <= 1'b1;
`endif
                    end
                end
                S_START: begin
                    if (tmr_q == '0) begin
                        state_q <= rx_s ? S_IDLE : S_DATA;
                        tmr_q   <= T_BIT;
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
                S_DATA: begin
                    if (tmr_q == '0) begin
                        shift_q <= {rx_s, shift_q[7:1]};
                        tmr_q   <= T_BIT;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tmr_q == '0) begin
                        par_ok_q <= (rx_s == ^shift_q);
                        state_q  <= S_STOP;
                        tmr_q    <= T_BIT;
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (tmr_q == '0) begin
                        state_q <= rx_s ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pop     = rd_en && (count_q != '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign wr_ok   = push_req && (!full || pop);
    assign ovr_set = push_req && full && !pop;
    assign count_d = count_q + CW'(wr_ok) - CW'(pop);

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            // set events take priority over a clear in the same cycle
            if (stop_bad || par_bad) frame_err_q <= 1'b1;
            else if (err_clr)        frame_err_q <= 1'b0;
            if (ovr_set)             overrun_q   <= 1'b1;
            else if (err_clr)        overrun_q   <= 1'b0;
        end
    end

    assign rx_valid   = (count_q != '0);
    assign rd_data    = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo (default 8N1 build): vector table, timing corner cases, random frames vs a queue model.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       reset, rx_i, rd_en, err_clr;
    logic [7:0] rd_data;
    logic       rx_valid, frame_err, overrun;
    logic [2:0] fifo_count;

    int total = 0;
    int bad   = 0;

    localparam int OP_FRM = 0;
    localparam int OP_POP = 1;
    localparam int OP_CLR = 2;

    typedef struct {
        int         op;
        logic [7:0] d;
        logic       stop;
        int         cnt;
        int         head;
        int         fe;
        int         ov;
    } vec_t;

    vec_t       tab [21];
    logic [7:0] q [$];
    int         m_fe, m_ov;

    uart_rx_fifo #(.CLKS_PER_BIT(12), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .rx_i(rx_i), .rd_en(rd_en), .err_clr(err_clr),
        .rd_data(rd_data), .rx_valid(rx_valid), .fifo_count(fifo_count),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int cnt, input int head,
                               input int fe, input int ov);
        chk({tag, " count"},     int'(fifo_count), cnt);
        chk({tag, " rd_data"},   int'(rd_data), head);
        chk({tag, " rx_valid"},  int'(rx_valid), (cnt != 0) ? 1 : 0);
        chk({tag, " frame_err"}, int'(frame_err), fe);
        chk({tag, " overrun"},   int'(overrun), ov);
    endtask

    // one bit = 12 clocks; frame start to next frame start is about 180 clocks
    task automatic send_frame(input logic [7:0] d, input logic stop, input int low_hold);
        rx_i = 1'b0;
        tick(12);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            tick(12);
        end
        rx_i = stop;
        tick(12);
        if (!stop) begin
            tick(low_hold);
            rx_i = 1'b1;
        end
        tick(60);
    endtask

    task automatic do_pop();
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic do_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    function automatic int m_head();
        return (q.size() > 0) ? int'(q[0]) : 0;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0]  = '{OP_FRM, 8'h02, 1'b1, 1, 'h02, 0, 0};
        tab[1]  = '{OP_FRM, 8'h03, 1'b1, 2, 'h02, 0, 0};
        tab[2]  = '{OP_FRM, 8'h0C, 1'b1, 3, 'h02, 0, 0};
        tab[3]  = '{OP_POP, 8'h00, 1'b1, 2, 'h03, 0, 0};
        tab[4]  = '{OP_POP, 8'h00, 1'b1, 1, 'h0C, 0, 0};
        tab[5]  = '{OP_POP, 8'h00, 1'b1, 0, 'h00, 0, 0};
        tab[6]  = '{OP_POP, 8'h00, 1'b1, 0, 'h00, 0, 0};
        tab[7]  = '{OP_FRM, 8'h55, 1'b0, 0, 'h00, 1, 0};
        tab[8]  = '{OP_FRM, 8'h5A, 1'b1, 1, 'h5A, 1, 0};
        tab[9]  = '{OP_CLR, 8'h00, 1'b1, 1, 'h5A, 0, 0};
        tab[10] = '{OP_POP, 8'h00, 1'b1, 0, 'h00, 0, 0};
        tab[11] = '{OP_FRM, 8'h01, 1'b1, 1, 'h01, 0, 0};
        tab[12] = '{OP_FRM, 8'h02, 1'b1, 2, 'h01, 0, 0};
        tab[13] = '{OP_FRM, 8'h03, 1'b1, 3, 'h01, 0, 0};
        tab[14] = '{OP_FRM, 8'h04, 1'b1, 4, 'h01, 0, 0};
        tab[15] = '{OP_FRM, 8'h05, 1'b1, 4, 'h01, 0, 1};
        tab[16] = '{OP_POP, 8'h00, 1'b1, 3, 'h02, 0, 1};
        tab[17] = '{OP_POP, 8'h00, 1'b1, 2, 'h03, 0, 1};
        tab[18] = '{OP_POP, 8'h00, 1'b1, 1, 'h04, 0, 1};
        tab[19] = '{OP_POP, 8'h00, 1'b1, 0, 'h00, 0, 1};
        tab[20] = '{OP_CLR, 8'h00, 1'b1, 0, 'h00, 0, 0};

        reset = 1'b0; rx_i = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        tick(3);
        check_state("reset", 0, 0, 0, 0);
        rd_en = 1'b1;
        tick(2);
        rd_en = 1'b0;
        check_state("reset rd_en", 0, 0, 0, 0);
        reset = 1'b1;
        tick(5);
        do_pop();
        check_state("pop empty", 0, 0, 0, 0);

        rx_i = 1'b0;
        tick(3);
        rx_i = 1'b1;
        tick(30);
        check_state("glitch", 0, 0, 0, 0);

        fork
            send_frame(8'hA7, 1'b1, 0);
            begin
                tick(116);
                chk("valid before edge 116", int'(rx_valid), 0);
                tick(1);
                chk("valid at edge 116", int'(rx_valid), 1);
                chk("data at edge 116", int'(rd_data), 'hA7);
            end
        join
        do_pop();
        check_state("first pop", 0, 0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            case (tab[i].op)
                OP_FRM:  send_frame(tab[i].d, tab[i].stop, 40);
                OP_POP:  do_pop();
                default: do_clr();
            endcase
            check_state($sformatf("vec%0d", i), tab[i].cnt, tab[i].head, tab[i].fe, tab[i].ov);
        end

        for (int i = 0; i < 4; i++) send_frame(8'(8'h11 + i), 1'b1, 0);
        check_state("full", 4, 'h11, 0, 0);
        fork
            send_frame(8'h06, 1'b1, 0);
            begin
                tick(116);
                rd_en = 1'b1;
                tick(1);
                rd_en = 1'b0;
            end
        join
        check_state("push+pop full", 4, 'h12, 0, 0);
        do_pop();
        do_pop();
        check_state("drain 2", 2, 'h14, 0, 0);
        do_pop();
        check_state("drain 3", 1, 'h06, 0, 0);
        do_pop();
        check_state("drain 4", 0, 0, 0, 0);

        m_fe = 0;
        m_ov = 0;
        for (int it = 0; it < 20; it++) begin
            logic [7:0] d;
            logic       stop;
            int         np;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 6) != 0);
            send_frame(d, stop, $urandom_range(0, 20));
            if (!stop)            m_fe = 1;
            else if (q.size() < 4) q.push_back(d);
            else                  m_ov = 1;
            check_state($sformatf("rnd%0d frame", it), q.size(), m_head(), m_fe, m_ov);
            np = $urandom_range(0, 2);
            for (int p = 0; p < np; p++) begin
                do_pop();
                if (q.size() > 0) void'(q.pop_front());
                check_state($sformatf("rnd%0d pop", it), q.size(), m_head(), m_fe, m_ov);
            end
            if ($urandom_range(0, 3) == 0) begin
                do_clr();
                m_fe = 0;
                m_ov = 0;
                check_state($sformatf("rnd%0d clr", it), q.size(), m_head(), m_fe, m_ov);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
